// File: rtl/mss_uart_fabric_rx.sv
// Fabric-side 8N1 receiver for the MSS MMUART TXD line: 16x oversampled decode
// feeding a small show-ahead FIFO with framing-error pulse and sticky overflow.
module mss_uart_fabric_rx #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK_BASE,
  input  logic                          FAB_RESET_N,
  input  logic                          MMUART_TXD_M2F,
  output logic [7:0]                    RX_DATA,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic [$clog2(FIFO_DEPTH):0]   RX_COUNT,
  output logic                          FERR,
  output logic                          OVF,
  input  logic                          OVF_CLR,
  output logic                          BUSY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [11:0]   TICK_LAST = 12'(BAUD_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic [11:0]   tick_cnt_r;
  state_t        state_r;
  logic [3:0]    samp_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          ferr_r;
  logic          busy_r;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          valid_r;
  logic          ovf_r;

  logic          tick_s;
  logic          fall_s;
  logic          start_s;
  logic          stop_smp_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_s;
  logic          ovf_set_s;
  logic [CW-1:0] count_next_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge CLK_BASE or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= MMUART_TXD_M2F;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Control strobes and FIFO handshake decode
  always_comb begin
    tick_s     = (tick_cnt_r == TICK_LAST);
    fall_s     = prev_r & ~sync2_r;
    start_s    = (state_r == IDLE) && fall_s;
    stop_smp_s = (state_r == STOP) && tick_s && (samp_r == 4'd15);
    push_s     = stop_smp_s && sync2_r;
    pop_s      = valid_r && RX_READY;
    full_s     = (count_r == FULL_CNT);
    wr_s       = push_s && (!full_s || pop_s);
    ovf_set_s  = push_s && full_s && !pop_s;
    if (wr_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!wr_s && pop_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Free-running oversample tick, re-phased to the detected start edge
  always_ff @(posedge CLK_BASE or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      tick_cnt_r <= 12'd0;
    end else if (start_s || tick_s) begin
      tick_cnt_r <= 12'd0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 12'd1;
    end
  end

  // Receiver FSM: start validation at mid-bit, then one sample per 16 ticks
  always_ff @(posedge CLK_BASE or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      state_r   <= IDLE;
      samp_r    <= 4'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      ferr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fall_s) begin
            state_r <= START;
            samp_r  <= 4'd0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            if (samp_r == 4'd7) begin
              samp_r <= 4'd0;
              if (!sync2_r) begin
                state_r   <= DATA;
                bit_idx_r <= 3'd0;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              samp_r <= samp_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (samp_r == 4'd15) begin
              samp_r  <= 4'd0;
              shift_r <= {sync2_r, shift_r[7:1]};
              if (bit_idx_r == 3'd7) begin
                state_r <= STOP;
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end else begin
              samp_r <= samp_r + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (samp_r == 4'd15) begin
              samp_r <= 4'd0;
              if (sync2_r) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                ferr_r  <= 1'b1;
                state_r <= WAIT_HIGH;
              end
            end else begin
              samp_r <= samp_r + 4'd1;
            end
          end
        end
        // A held-low line (break) must return high before a new frame is hunted
        WAIT_HIGH: begin
          if (sync2_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Receive FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge CLK_BASE or negedge FAB_RESET_N) begin
    if (!FAB_RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != '0);
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (OVF_CLR) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign RX_DATA  = mem_r[rd_ptr_r];
  assign RX_VALID = valid_r;
  assign RX_COUNT = count_r;
  assign FERR     = ferr_r;
  assign OVF      = ovf_r;
  assign BUSY     = busy_r;

endmodule

// File: tb/tb_mss_uart_fabric_rx.sv
// Directed bench for mss_uart_fabric_rx at BAUD_DIV=4 (64 clocks per bit):
// a vector table of single frames plus hand-timed multi-cycle sequences.
module tb_mss_uart_fabric_rx;

  logic       clk;
  logic       rst_n;
  logic       txd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] rx_count;
  logic       ferr;
  logic       ovf;
  logic       ovf_clr;
  logic       busy;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int f0;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_count;
    int         exp_valid;
    int         exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs [5];

  mss_uart_fabric_rx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .CLK_BASE      (clk),
    .FAB_RESET_N   (rst_n),
    .MMUART_TXD_M2F(txd),
    .RX_DATA       (rx_data),
    .RX_VALID      (rx_valid),
    .RX_READY      (rx_ready),
    .RX_COUNT      (rx_count),
    .FERR          (ferr),
    .OVF           (ovf),
    .OVF_CLR       (ovf_clr),
    .BUSY          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ferr) ferr_cnt = ferr_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Edge 0 is the first posedge inside the task; the line changes 2ns after edges.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len);
    @(posedge clk); #2 txd = 1'b0;
    repeat (64) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #2 txd = d[i];
      repeat (64) @(posedge clk);
    end
    #2 txd = stop_bit;
    repeat (stop_len) @(posedge clk);
    #2 txd = 1'b1;
  endtask

  task automatic pop_one();
    @(posedge clk); #2 rx_ready = 1'b1;
    @(posedge clk); #2 rx_ready = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; txd = 1'b1; rx_ready = 1'b0; ovf_clr = 1'b0;
    vecs[0] = '{8'h5A, 1'b1, 1, 1, 8'h5A, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 1, 8'h00, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 1, 8'hFF, 0};
    vecs[3] = '{8'h81, 1'b0, 0, 0, 8'h00, 1};
    vecs[4] = '{8'h6E, 1'b1, 1, 1, 8'h6E, 0};

    #3 rst_n = 1'b0;
    wait_clks(3);
    chk("rst_count", rx_count, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    wait_clks(10);

    // Scenario 1: 0xA5, RX_VALID rises right after the stop sample (edge 611)
    f0 = ferr_cnt;
    fork send_frame(8'hA5, 1'b1, 64); join_none
    @(posedge clk);
    repeat (610) @(posedge clk);
    #1 chk("s1_valid_before_stop", rx_valid, 0);
    @(posedge clk);
    #1 chk("s1_valid_after_stop", rx_valid, 1);
    wait_clks(40);
    chk("s1_data", rx_data, 8'hA5);
    chk("s1_count", rx_count, 1);
    chk("s1_ferr", ferr_cnt - f0, 0);
    wait_clks(30);
    chk("s1_data_held", rx_data, 8'hA5);
    pop_one();
    chk("s1_count_after_pop", rx_count, 0);
    chk("s1_valid_after_pop", rx_valid, 0);

    // Vector table: one frame each, then drain
    for (int v = 0; v < 5; v++) begin
      f0 = ferr_cnt;
      send_frame(vecs[v].d, vecs[v].stop, 64);
      wait_clks(20);
      chk($sformatf("vec%0d_count", v), rx_count, vecs[v].exp_count);
      chk($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_busy", v), busy, 0);
      if (vecs[v].exp_valid != 0) begin
        chk($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
        pop_one();
        chk($sformatf("vec%0d_drained", v), rx_count, 0);
      end
    end

    // Scenario 2: 20-clock glitch, then pop on an empty FIFO
    f0 = ferr_cnt;
    @(posedge clk); #2 txd = 1'b0;
    wait_clks(10);
    chk("s2_busy_in_glitch", busy, 1);
    repeat (10) @(posedge clk);
    #2 txd = 1'b1;
    wait_clks(20);
    chk("s2_busy_back", busy, 0);
    chk("s2_count", rx_count, 0);
    chk("s2_ferr", ferr_cnt - f0, 0);
    pop_one();
    chk("s2_pop_empty_count", rx_count, 0);
    chk("s2_pop_empty_valid", rx_valid, 0);

    // Scenario 3: 0x3C with low stop bit, line held low 200 more clocks
    f0 = ferr_cnt;
    fork send_frame(8'h3C, 1'b0, 264); join_none
    @(posedge clk);
    wait_clks(700);
    chk("s3_ferr_pulse", ferr_cnt - f0, 1);
    chk("s3_count", rx_count, 0);
    wait_clks(138);
    chk("s3_busy_while_low", busy, 1);
    wait_clks(12);
    chk("s3_busy_after_high", busy, 0);
    chk("s3_ferr_single", ferr_cnt - f0, 1);
    chk("s3_count_after", rx_count, 0);

    // Scenario 4: five bytes with no reads; OVF_CLR lands on the overflowing push
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 64);
    wait_clks(5);
    chk("s4_count_full", rx_count, 4);
    chk("s4_ovf_not_yet", ovf, 0);
    fork send_frame(8'h05, 1'b1, 64); join_none
    @(posedge clk);
    repeat (610) @(posedge clk);
    #2 ovf_clr = 1'b1;
    @(posedge clk);
    #2 ovf_clr = 1'b0;
    #1 chk("s4_ovf_set_wins", ovf, 1);
    wait_clks(40);
    chk("s4_count", rx_count, 4);
    chk("s4_ovf_sticky", ovf, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("s4_read%0d", i), rx_data, i);
      pop_one();
    end
    chk("s4_empty", rx_count, 0);
    @(posedge clk); #2 ovf_clr = 1'b1;
    @(posedge clk); #2 ovf_clr = 1'b0;
    chk("s4_ovf_cleared", ovf, 0);

    // Scenario 5: full FIFO, pop coincides with the 0x55 push
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 64);
    fork send_frame(8'h55, 1'b1, 64); join_none
    @(posedge clk);
    repeat (610) @(posedge clk);
    #2 rx_ready = 1'b1;
    @(posedge clk);
    #2 rx_ready = 1'b0;
    wait_clks(40);
    chk("s5_ovf", ovf, 0);
    chk("s5_count", rx_count, 4);
    for (int i = 2; i <= 4; i++) begin
      chk($sformatf("s5_read%0d", i), rx_data, 8'h10 + i);
      pop_one();
    end
    chk("s5_last_entry", rx_data, 8'h55);
    chk("s5_last_count", rx_count, 1);

    // Scenario 6: reset during data bit 3, then a clean 0x7E
    @(posedge clk); #2 txd = 1'b0;
    repeat (64) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #2 txd = (i % 2 == 0);
      repeat (64) @(posedge clk);
    end
    repeat (32) @(posedge clk);
    #2 rst_n = 1'b0; txd = 1'b1;
    #1 chk("s6_rst_count", rx_count, 0);
    chk("s6_rst_valid", rx_valid, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_data", rx_data, 8'h00);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_clks(100);
    f0 = ferr_cnt;
    send_frame(8'h7E, 1'b1, 64);
    wait_clks(20);
    chk("s6_count", rx_count, 1);
    chk("s6_data", rx_data, 8'h7E);
    chk("s6_valid", rx_valid, 1);
    chk("s6_ferr", ferr_cnt - f0, 0);
    pop_one();
    chk("s6_drained", rx_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
